control_sequencer: RTL and testbench

- Multicycle fetch/decode sequencer that produces the per-instruction control word consumed by the RV32I datapath.
  - Control word: inst_type, fun3, fun7, rd, rs1, rs2, pc, imm.
- Owns the PC and the instruction-memory read port.
- Holds each control word stable for EXEC_CYCLES clocks, then resolves the next PC itself (sequential, branch, JAL, JALR) from register operands fed back by the datapath.
- Stops in a trap state on illegal or misaligned flow.

---
 rtl/control_sequencer_pkg.sv | 41 ++++
 rtl/control_sequencer_imm_gen.sv | 32 +++
 rtl/control_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: inst_type codes, RV32I opcodes,
// branch fun3 encodings and the sequencer state enum.
package control_sequencer_pkg;

    localparam logic [3:0] IT_LOAD  = 4'd0;
    localparam logic [3:0] IT_IMM   = 4'd1;
    localparam logic [3:0] IT_STORE = 4'd2;
    localparam logic [3:0] IT_REG   = 4'd3;
    localparam logic [3:0] IT_LUI   = 4'd4;
    localparam logic [3:0] IT_AUIPC = 4'd5;
    localparam logic [3:0] IT_BRNCH = 4'd6;
    localparam logic [3:0] IT_JALR  = 4'd7;
    localparam logic [3:0] IT_JAL   = 4'd8;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

endpackage

// File: rtl/control_sequencer_imm_gen.sv
// Combinational RV32I immediate generator, selecting the format from the
// already-decoded inst_type.
module imm_gen
    import control_sequencer_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [3:0]  inst_type_i,
    output logic [31:0] imm_o
);

    // Format select; register-register ops carry no immediate.
    always_comb begin
        imm_o = 32'd0;
        case (inst_type_i)
            IT_LOAD, IT_IMM, IT_JALR:
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IT_STORE:
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IT_BRNCH:
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            IT_LUI, IT_AUIPC:
                imm_o = {instr_i[31:12], 12'd0};
            IT_JAL:
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle RV32I fetch/decode sequencer that owns the PC and emits the control word.
// Optional retired-instruction counter: define CONTROL_SEQUENCER_INSTRET_EN.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int          IMEM_AW     = 7,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          EXEC_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rd_dout,
    input  logic [31:0]        rs1_data,
    input  logic [31:0]        rs2_data,
    output logic [3:0]         inst_type,
    output logic [2:0]         fun3,
    output logic               fun7,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [31:0]        pc,
    output logic [31:0]        imm,
    output logic               ctrl_valid,
    output logic               halt,
    output logic [31:0]        instret
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         type_q;
    logic [3:0]         inst_type_q;
    logic [2:0]         fun3_q;
    logic               fun7_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [31:0]        imm_q;
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic               ctrl_valid_q;
    logic               halt_q;

    logic [3:0]         dec_type_s;
    logic               dec_legal_s;
    logic               dec_fun7_s;
    logic [31:0]        dec_imm_s;
    logic [31:0]        next_pc_d;
    logic               br_taken_s;
    logic               br_illegal_s;
    logic               commit_trap_s;

    // Opcode decode of the word returned by instruction memory.
    always_comb begin
        dec_type_s  = IT_BRNCH;
        dec_legal_s = 1'b1;
        case (imem_rd_dout[6:0])
            OP_LOAD:  dec_type_s = IT_LOAD;
            OP_IMM:   dec_type_s = IT_IMM;
            OP_STORE: dec_type_s = IT_STORE;
            OP_REG:   dec_type_s = IT_REG;
            OP_LUI:   dec_type_s = IT_LUI;
            OP_AUIPC: dec_type_s = IT_AUIPC;
            OP_BRNCH: dec_type_s = IT_BRNCH;
            OP_JALR:  dec_type_s = IT_JALR;
            OP_JAL:   dec_type_s = IT_JAL;
            default:  dec_legal_s = 1'b0;
        endcase
        if ((dec_type_s == IT_REG) ||
            ((dec_type_s == IT_IMM) && (imem_rd_dout[14:12] == 3'b101))) begin
            dec_fun7_s = imem_rd_dout[30];
        end else begin
            dec_fun7_s = 1'b0;
        end
    end

    imm_gen u_imm_gen (
        .instr_i     (imem_rd_dout),
        .inst_type_i (dec_type_s),
        .imm_o       (dec_imm_s)
    );

    // Next-PC resolution from the operands captured in the last EXEC clock.
    always_comb begin
        br_taken_s   = 1'b0;
        br_illegal_s = 1'b0;
        next_pc_d    = pc_q + 32'd4;
        case (type_q)
            IT_BRNCH: begin
                case (fun3_q)
                    F3_BEQ:  br_taken_s = (op_a_q == op_b_q);
                    F3_BNE:  br_taken_s = (op_a_q != op_b_q);
                    F3_BLT:  br_taken_s = ($signed(op_a_q) <  $signed(op_b_q));
                    F3_BGE:  br_taken_s = ($signed(op_a_q) >= $signed(op_b_q));
                    F3_BLTU: br_taken_s = (op_a_q <  op_b_q);
                    F3_BGEU: br_taken_s = (op_a_q >= op_b_q);
                    default: br_illegal_s = 1'b1;
                endcase
                if (br_taken_s) begin
                    next_pc_d = pc_q + imm_q;
                end else begin
                    next_pc_d = pc_q + 32'd4;
                end
            end
            IT_JAL:  next_pc_d = pc_q + imm_q;
            IT_JALR: next_pc_d = (op_a_q + imm_q) & ~32'd1;
            default: next_pc_d = pc_q + 32'd4;
        endcase
        commit_trap_s = br_illegal_s | next_pc_d[1];
    end

    // Sequencer FSM with registered control-word outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            type_q       <= IT_BRNCH;
            inst_type_q  <= IT_BRNCH;
            fun3_q       <= 3'd0;
            fun7_q       <= 1'b0;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            imm_q        <= 32'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            ctrl_valid_q <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_WAIT;
                S_WAIT:   state_q <= S_DECODE;
                S_DECODE: begin
                    if (dec_legal_s) begin
                        type_q       <= dec_type_s;
                        inst_type_q  <= dec_type_s;
                        fun3_q       <= imem_rd_dout[14:12];
                        fun7_q       <= dec_fun7_s;
                        rd_q         <= imem_rd_dout[11:7];
                        rs1_q        <= imem_rd_dout[19:15];
                        rs2_q        <= imem_rd_dout[24:20];
                        imm_q        <= dec_imm_s;
                        cnt_q        <= CNT_W'(EXEC_CYCLES - 1);
                        ctrl_valid_q <= 1'b1;
                        state_q      <= S_EXEC;
                    end else begin
                        halt_q       <= 1'b1;
                        state_q      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        op_a_q       <= rs1_data;
                        op_b_q       <= rs2_data;
                        ctrl_valid_q <= 1'b0;
                        inst_type_q  <= IT_BRNCH;
                        state_q      <= S_COMMIT;
                    end else begin
                        cnt_q        <= cnt_q - CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (commit_trap_s) begin
                        halt_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else begin
                        pc_q    <= next_pc_d;
                        state_q <= S_FETCH;
                    end
                end
                S_TRAP:   state_q <= S_TRAP;
                default: begin
                    ctrl_valid_q <= 1'b0;
                    inst_type_q  <= IT_BRNCH;
                    halt_q       <= 1'b1;
                    state_q      <= S_TRAP;
                end
            endcase
        end
    end

`ifdef CONTROL_SEQUENCER_INSTRET_EN
    logic [31:0] instret_q;

    // Retired-instruction counter, stepped by every non-trapping commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 32'd0;
        end else if ((state_q == S_COMMIT) && !commit_trap_s) begin
            instret_q <= instret_q + 32'd1;
        end else begin
            instret_q <= instret_q;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign inst_type  = inst_type_q;
    assign fun3       = fun3_q;
    assign fun7       = fun7_q;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign pc         = pc_q;
    assign imm        = imm_q;
    assign ctrl_valid = ctrl_valid_q;
    assign halt       = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer, plus hand-written
// sequences for reset, trap recovery and PC wrap-around.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rd_dout = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [3:0]  inst_type;
    logic [2:0]  fun3;
    logic        fun7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, imm, instret;
    logic        ctrl_valid, halt;

    logic [31:0] mem [128];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret;

    control_sequencer dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd_dout(imem_rd_dout),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .inst_type(inst_type),
        .fun3(fun3), .fun7(fun7), .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc),
        .imm(imm), .ctrl_valid(ctrl_valid), .halt(halt), .instret(instret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rd_dout <= mem[imem_addr];

    typedef struct {
        logic [31:0] vpc, instr, a, b;
        logic [3:0]  ty;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  erd, ers1, ers2;
        logic [31:0] eimm, npc;
        logic        trap;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic [31:0] vpc, instr, a, b, input logic [3:0] ty,
                                input logic [2:0] f3, input logic f7, input logic [4:0] erd,
                                input logic [4:0] ers1, ers2, input logic [31:0] eimm, npc,
                                input logic trap);
        vec_t v;
        v.vpc = vpc; v.instr = instr; v.a = a; v.b = b; v.ty = ty; v.f3 = f3; v.f7 = f7;
        v.erd = erd; v.ers1 = ers1; v.ers2 = ers2; v.eimm = eimm; v.npc = npc; v.trap = trap;
        return v;
    endfunction

    function automatic logic [31:0] j_enc(input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_instret(input int e);
`ifdef CONTROL_SEQUENCER_INSTRET_EN
        chk("instret", instret, e);
`else
        chk("instret", instret, (e > 0) ? 32'd0 : 32'd0);
`endif
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH through COMMIT; ends at the negedge after commit.
    task automatic run_instr(input logic chk_en, input logic [86:0] exp_w,
                             input logic [31:0] a, input logic [31:0] b);
        int w;
        int cyc;
        rs1_data = a;
        rs2_data = b;
        w = 0;
        while (!ctrl_valid && !halt && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ctrl_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL exec_start timeout pc=%0h halt=%0b", pc, halt);
            return;
        end
        cyc = 0;
        while (ctrl_valid && cyc < 10) begin
            if (chk_en) chk("ctrl_word", {inst_type, fun3, fun7, rd, rs1, rs2, imm, pc}, exp_w);
            cyc++;
            @(negedge clk);
        end
        if (chk_en) chk("exec_len", cyc, 3);
        @(negedge clk);
    endtask

    localparam logic [31:0] ADDI5 = 32'h0050_0093;

    initial begin
        int w;
        logic seen_valid;

        vt[0]  = mk(32'h00, ADDI5,        32'd0, 32'd0, 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5, 32'h04, 1'b0);
        vt[1]  = mk(32'h10, 32'h00208463, 32'd7, 32'd7, 4'd6, 3'd0, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h18, 1'b0);
        vt[2]  = mk(32'h10, 32'h00208463, 32'd7, 32'd8, 4'd6, 3'd0, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h14, 1'b0);
        vt[3]  = mk(32'h10, 32'h0020C463, 32'hFFFF_FFFF, 32'd1, 4'd6, 3'd4, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h18, 1'b0);
        vt[4]  = mk(32'h10, 32'h0020E463, 32'hFFFF_FFFF, 32'd1, 4'd6, 3'd6, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h14, 1'b0);
        vt[5]  = mk(32'h10, 32'h0020D463, 32'hFFFF_FFFF, 32'd1, 4'd6, 3'd5, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h14, 1'b0);
        vt[6]  = mk(32'h10, 32'h0020F463, 32'hFFFF_FFFF, 32'd1, 4'd6, 3'd7, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h18, 1'b0);
        vt[7]  = mk(32'h10, 32'h00209463, 32'd5, 32'd5, 4'd6, 3'd1, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h14, 1'b0);
        vt[8]  = mk(32'h10, 32'h0020A463, 32'd5, 32'd5, 4'd6, 3'd2, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'h10, 1'b1);
        vt[9]  = mk(32'h20, 32'h003100E7, 32'h100, 32'd0, 4'd7, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd3, 32'h20, 1'b1);
        vt[10] = mk(32'h40, 32'h123452B7, 32'd0, 32'd0, 4'd4, 3'd5, 1'b0, 5'd5, 5'd8, 5'd3, 32'h1234_5000, 32'h44, 1'b0);
        vt[11] = mk(32'h00, 32'h402081B3, 32'd0, 32'd0, 4'd3, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h04, 1'b0);
        vt[12] = mk(32'h00, 32'h4030D213, 32'd0, 32'd0, 4'd1, 3'd5, 1'b1, 5'd4, 5'd1, 5'd3, 32'h403, 32'h04, 1'b0);
        vt[13] = mk(32'h10, 32'hFE20AE23, 32'd0, 32'd0, 4'd2, 3'd2, 1'b0, 5'd28, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'h14, 1'b0);
        vt[14] = mk(32'h40, 32'hFF9FF0EF, 32'd0, 32'd0, 4'd8, 3'd7, 1'b0, 5'd1, 5'd31, 5'd25, 32'hFFFF_FFF8, 32'h38, 1'b0);
        vt[15] = mk(32'h10, 32'h00001397, 32'd0, 32'd0, 4'd5, 3'd1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1000, 32'h14, 1'b0);
        vt[16] = mk(32'h20, 32'h0080A303, 32'd0, 32'd0, 4'd0, 3'd2, 1'b0, 5'd6, 5'd1, 5'd8, 32'd8, 32'h24, 1'b0);
        vt[17] = mk(32'h20, 32'hFE2088E3, 32'd3, 32'd3, 4'd6, 3'd0, 1'b0, 5'd17, 5'd1, 5'd2, 32'hFFFF_FFF0, 32'h10, 1'b0);

        clear_mem();
        @(posedge clk);
        @(negedge clk);
        chk("reset_state", {ctrl_valid, halt, inst_type, fun3, fun7, rd, rs1, rs2, imm, pc, instret},
            {1'b0, 1'b0, 4'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0});

        foreach (vt[k]) begin
            clear_mem();
            if (vt[k].vpc != 32'd0) mem[0] = j_enc(vt[k].vpc);
            mem[vt[k].vpc[8:2]] = vt[k].instr;
            do_reset();
            exp_ret = 0;
            if (vt[k].vpc != 32'd0) begin
                run_instr(1'b0, 87'd0, 32'd0, 32'd0);
                exp_ret++;
            end
            run_instr(1'b1, {vt[k].ty, vt[k].f3, vt[k].f7, vt[k].erd, vt[k].ers1, vt[k].ers2,
                             vt[k].eimm, vt[k].vpc}, vt[k].a, vt[k].b);
            if (!vt[k].trap) exp_ret++;
            chk("halt", halt, vt[k].trap);
            chk("next_pc", pc, vt[k].trap ? vt[k].vpc : vt[k].npc);
            chk("idle_type", inst_type, 4'd6);
            chk("ctrl_valid_idle", ctrl_valid, 1'b0);
            chk_instret(exp_ret);
        end

        // PC wrap: jalr to 0xFFFFFFFC, then the instruction there falls through to 0.
        clear_mem();
        mem[0]   = 32'h0000_8067;
        mem[127] = ADDI5;
        do_reset();
        run_instr(1'b1, {4'd7, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'd0}, 32'hFFFF_FFFC, 32'd0);
        chk("wrap_jalr_pc", {halt, pc}, {1'b0, 32'hFFFF_FFFC});
        chk("wrap_imem_addr", imem_addr, 7'h7F);
        run_instr(1'b1, {4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5, 32'hFFFF_FFFC}, 32'd0, 32'd0);
        chk("wrap_pc", {halt, pc}, {1'b0, 32'd0});
        chk_instret(2);

        // Illegal opcode traps from DECODE, then a one-clock reset recovers.
        clear_mem();
        mem[0] = 32'h0000_0073;
        do_reset();
        seen_valid = 1'b0;
        w = 0;
        while (!halt && w < 20) begin
            @(negedge clk);
            if (ctrl_valid) seen_valid = 1'b1;
            w++;
        end
        chk("illegal_halt", halt, 1'b1);
        chk("illegal_no_valid", seen_valid, 1'b0);
        chk("illegal_state", {inst_type, pc}, {4'd6, 32'd0});
        repeat (3) @(negedge clk);
        chk("trap_held", {halt, ctrl_valid}, {1'b1, 1'b0});
        mem[0] = ADDI5;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("recover_state", {halt, pc}, {1'b0, 32'd0});
        chk_instret(0);
        run_instr(1'b1, {4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5, 32'd0}, 32'd0, 32'd0);
        chk("recover_pc", {halt, pc}, {1'b0, 32'd4});
        chk_instret(1);

        // Asynchronous reset in the second EXEC clock.
        clear_mem();
        mem[0] = ADDI5;
        do_reset();
        w = 0;
        while (!ctrl_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midexec_started", ctrl_valid, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midexec_reset", {ctrl_valid, inst_type, halt, pc, imm, rd},
            {1'b0, 4'd6, 1'b0, 32'd0, 32'd0, 5'd0});
        chk_instret(0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
